// File: rtl/psram_arbiter.sv
// Round-robin arbiter sharing one SPI PSRAM engine between two requesters.
// One transaction in flight, CE-high gap between transactions, watchdog abort.
module psram_arbiter #(
    parameter int ADDRLEN = 23,
    parameter int GAP_CYC = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic               sysclk,
    input  logic               rst_n,
    input  logic               req0,
    input  logic               req1,
    input  logic               we0,
    input  logic               we1,
    input  logic [ADDRLEN-1:0] addr0,
    input  logic [ADDRLEN-1:0] addr1,
    input  logic [7:0]         wdata0,
    input  logic [7:0]         wdata1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               done0,
    output logic               done1,
    output logic [7:0]         rdata,
    output logic               tmo,
    output logic               eng_start,
    output logic               eng_we,
    output logic [ADDRLEN-1:0] eng_addr,
    output logic [7:0]         eng_wdata,
    input  logic               eng_busy,
    input  logic               eng_done,
    input  logic [7:0]         eng_rdata,
    output logic [15:0]        xact_cnt,
    output logic [7:0]         tmo_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        GAP
    } state_t;

    state_t        state;
    logic          owner;
    logic          last;
    logic [TW-1:0] wdog;
    logic [GW-1:0] gap;

    logic pick;
    logic fin;
    logic fin_tmo;

    // On a tie the port not served last wins.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

    // eng_done takes priority over a watchdog expiring in the same cycle.
    always_comb begin
        fin     = 1'b0;
        fin_tmo = 1'b0;
        if (state == WAIT) begin
            if (eng_done) begin
                fin = 1'b1;
            end else if (wdog == TW'(1)) begin
                fin     = 1'b1;
                fin_tmo = 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            wdog      <= '0;
            gap       <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            rdata     <= '0;
            tmo       <= 1'b0;
            eng_start <= 1'b0;
            eng_we    <= 1'b0;
            eng_addr  <= '0;
            eng_wdata <= '0;
            xact_cnt  <= '0;
            tmo_cnt   <= '0;
        end else begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            tmo       <= 1'b0;
            eng_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if ((req0 || req1) && !eng_busy) begin
                        owner     <= pick;
                        eng_we    <= pick ? we1 : we0;
                        eng_addr  <= pick ? addr1 : addr0;
                        eng_wdata <= pick ? wdata1 : wdata0;
                        gnt0      <= ~pick;
                        gnt1      <= pick;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    eng_start <= 1'b1;
                    wdog      <= TW'(TIMEOUT);
                    state     <= WAIT;
                end
                WAIT: begin
                    if (fin) begin
                        if (!fin_tmo && !eng_we) begin
                            rdata <= eng_rdata;
                        end
                        if (fin_tmo && tmo_cnt != 8'hff) begin
                            tmo_cnt <= tmo_cnt + 8'd1;
                        end
                        done0    <= ~owner;
                        done1    <= owner;
                        tmo      <= fin_tmo;
                        xact_cnt <= xact_cnt + 16'd1;
                        last     <= owner;
                        gap      <= GW'(GAP_CYC);
                        state    <= (GAP_CYC == 0) ? IDLE : GAP;
                    end else begin
                        wdog <= wdog - TW'(1);
                    end
                end
                GAP: begin
                    if (gap <= GW'(1)) begin
                        state <= IDLE;
                    end else begin
                        gap <= gap - GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
